// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU controller and the execution datapath:
// opcode encoding and default widths.
package cpu_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int ADDR_W_DEF      = 12;
  localparam int STACK_DEPTH_DEF = 8;

  typedef enum logic [3:0] {
    OP_HLT  = 4'h0,
    OP_SKZ  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_MUL  = 4'h4,
    OP_OR   = 4'h5,
    OP_AND  = 4'h6,
    OP_XOR  = 4'h7,
    OP_NOT  = 4'h8,
    OP_LDA  = 4'h9,
    OP_STO  = 4'hA,
    OP_JMP  = 4'hB,
    OP_RL   = 4'hC,
    OP_RR   = 4'hD,
    OP_POP  = 4'hE,
    OP_PUSH = 4'hF
  } opcode_t;

endpackage

// File: rtl/acc_stack.sv
// Small LIFO backing the PUSH/POP instructions. Only the pointer is reset;
// the storage keeps whatever it held. Pushes when full and pops when empty
// are ignored here; the datapath flags them as stack errors.
module acc_stack
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = STACK_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW:0]       sp;
  logic [PW-1:0]     top_idx;

  assign full    = (sp == FULL_CNT);
  assign empty   = (sp == '0);
  assign top_idx = sp[PW-1:0] - (PW)'(1);
  assign dout    = mem[top_idx];

  // Stack pointer: counts occupied entries, guarded against over/underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + (PW+1)'(1);
    end else if (pop && !empty) begin
      sp <= sp - (PW+1)'(1);
    end
  end

  // Storage write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[PW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/exec_datapath.sv
// Execution datapath: PC, IR, accumulator, ALU and hardware stack, driven by
// strobes from the controller (updated on falling edge, sampled here on the
// rising edge). Once halted, all load strobes and memory enables are blocked
// until reset.
module exec_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_pc,
  input  logic              load_pc,
  input  logic              load_ir,
  input  logic              load_acc,
  input  logic              rd,
  input  logic              wr,
  input  logic              datactl_ena,
  input  logic              halt,
  output logic [3:0]        opcode,
  output logic              zero,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic              halted,
  output logic              stk_err
);

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] acc;
  logic [ADDR_W-1:0] ir_addr;
  opcode_t           op;
  logic              en;
  logic              do_push;
  logic              do_pop;
  logic              stk_full;
  logic              stk_empty;
  logic [DATA_W-1:0] stk_dout;
  logic [DATA_W-1:0] alu_out;

  function automatic logic [DATA_W-1:0] alu(input opcode_t f,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = a;
    case (f)
      OP_ADD:  r = a + d;
      OP_SUB:  r = a - d;
      OP_MUL:  r = a * d;
      OP_OR:   r = a | d;
      OP_AND:  r = a & d;
      OP_XOR:  r = a ^ d;
      OP_NOT:  r = ~a;
      OP_LDA:  r = d;
      OP_RL:   r = {a[DATA_W-2:0], a[DATA_W-1]};
      OP_RR:   r = {a[0], a[DATA_W-1:1]};
      default: r = a;
    endcase
    return r;
  endfunction

  assign ir_addr   = ir[ADDR_W-1:0];
  assign op        = opcode_t'(ir[DATA_W-1:DATA_W-4]);
  assign opcode    = ir[DATA_W-1:DATA_W-4];
  assign zero      = (acc == '0);
  assign mem_addr  = load_ir ? pc : ir_addr;
  assign mem_wdata = acc;
  assign mem_re    = rd & ~halted;
  assign mem_we    = wr & datactl_ena & ~halted;

  // A halt in the same cycle as a load strobe suppresses that load.
  assign en      = ~halted & ~halt;
  assign do_push = en & load_acc & (op == OP_PUSH);
  assign do_pop  = en & load_acc & (op == OP_POP);
  assign alu_out = alu(op, acc, mem_rdata);

  acc_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (do_push),
    .pop   (do_pop),
    .din   (acc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Architectural registers and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      acc     <= '0;
      halted  <= 1'b0;
      stk_err <= 1'b0;
    end else begin
      if (halt) begin
        halted <= 1'b1;
      end
      if (en && load_ir) begin
        ir <= mem_rdata;
      end
      if (en && load_pc) begin
        pc <= ir_addr;
      end else if (en && inc_pc) begin
        pc <= pc + (ADDR_W)'(1);
      end
      if (en && load_acc) begin
        case (op)
          OP_POP:  if (!stk_empty) acc <= stk_dout;
          OP_PUSH: acc <= acc;
          default: acc <= alu_out;
        endcase
      end
      if ((do_push && stk_full) || (do_pop && stk_empty)) begin
        stk_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exec_datapath.sv
// Directed bench for exec_datapath. Strobes are driven after the falling
// edge and cleared just after the rising edge; registered results are
// observed 1ns after the rising edge. The PC is observed through mem_addr
// by raising load_ir briefly between edges.
module tb_exec_datapath;

  logic        clk;
  logic        rst_n;
  logic        inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt;
  logic [3:0]  opcode;
  logic        zero;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] mem_wdata;
  logic        mem_re, mem_we, halted, stk_err;

  int n_pass;
  int n_total;

  localparam logic [7:0] S_INC  = 8'h01;
  localparam logic [7:0] S_LPC  = 8'h02;
  localparam logic [7:0] S_LIR  = 8'h04;
  localparam logic [7:0] S_LACC = 8'h08;
  localparam logic [7:0] S_RD   = 8'h10;
  localparam logic [7:0] S_WR   = 8'h20;
  localparam logic [7:0] S_DENA = 8'h40;
  localparam logic [7:0] S_HALT = 8'h80;

  exec_datapath dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_ir     (load_ir),
    .load_acc    (load_acc),
    .rd          (rd),
    .wr          (wr),
    .datactl_ena (datactl_ena),
    .halt        (halt),
    .opcode      (opcode),
    .zero        (zero),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_wdata   (mem_wdata),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .halted      (halted),
    .stk_err     (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] s);
    inc_pc      = s[0];
    load_pc     = s[1];
    load_ir     = s[2];
    load_acc    = s[3];
    rd          = s[4];
    wr          = s[5];
    datactl_ena = s[6];
    halt        = s[7];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given strobes and read data.
  task automatic cyc(input logic [7:0] s, input logic [15:0] d);
    @(negedge clk);
    drive(s);
    mem_rdata = d;
    @(posedge clk);
    #1;
    drive(8'h00);
  endtask

  task automatic peek_pc(input string tag, input logic [11:0] exp);
    @(negedge clk);
    load_ir = 1'b1;
    #1;
    chk(tag, 32'(mem_addr), 32'(exp));
    load_ir = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    mem_rdata = '0;
    drive(8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_zero", 32'(zero), 32'h1);
    chk("rst_acc", 32'(mem_wdata), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_stk_err", 32'(stk_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    peek_pc("rst_pc", 12'h000);

    // Fetch with increment reads the old pc.
    @(negedge clk);
    drive(S_LIR | S_INC);
    mem_rdata = 16'hA005;
    #1;
    chk("fetch_addr", 32'(mem_addr), 32'h000);
    @(posedge clk);
    #1;
    drive(8'h00);
    chk("fetch_opcode", 32'(opcode), 32'hA);
    peek_pc("fetch_pc", 12'h001);
    cyc(S_LACC, 16'h0000);
    chk("sto_acc", 32'(mem_wdata), 32'h0);
    chk("sto_zero", 32'(zero), 32'h1);

    // Arithmetic
    cyc(S_LIR, 16'h9000);
    cyc(S_LACC, 16'hFFFF);
    chk("lda_acc", 32'(mem_wdata), 32'hFFFF);
    chk("lda_zero", 32'(zero), 32'h0);
    cyc(S_LIR, 16'h2000);
    cyc(S_LACC, 16'h0001);
    chk("add_wrap", 32'(mem_wdata), 32'h0000);
    chk("add_zero", 32'(zero), 32'h1);
    cyc(S_LIR, 16'h3000);
    cyc(S_LACC, 16'h0001);
    chk("sub_borrow", 32'(mem_wdata), 32'hFFFF);
    cyc(S_LIR, 16'h9000);
    cyc(S_LACC, 16'h0100);
    cyc(S_LIR, 16'h4000);
    cyc(S_LACC, 16'h0100);
    chk("mul_low", 32'(mem_wdata), 32'h0000);
    cyc(S_LIR, 16'h9000);
    cyc(S_LACC, 16'h8001);
    cyc(S_LIR, 16'hC000);
    cyc(S_LACC, 16'h0000);
    chk("rl", 32'(mem_wdata), 32'h0003);
    cyc(S_LIR, 16'hD000);
    cyc(S_LACC, 16'h0000);
    chk("rr", 32'(mem_wdata), 32'h8001);
    cyc(S_LIR, 16'h7000);
    cyc(S_LACC, 16'hFFFF);
    chk("xor", 32'(mem_wdata), 32'h7FFE);

    // Jumps and pc wrap
    cyc(S_LIR, 16'hB123);
    cyc(S_LPC, 16'h0000);
    peek_pc("jmp_pc", 12'h123);
    cyc(S_LPC | S_INC, 16'h0000);
    peek_pc("jmp_prio", 12'h123);
    cyc(S_LIR, 16'hBFFF);
    cyc(S_LPC, 16'h0000);
    peek_pc("jmp_fff", 12'hFFF);
    cyc(S_INC, 16'h0000);
    peek_pc("pc_wrap", 12'h000);

    // Store
    cyc(S_LIR, 16'hA456);
    @(negedge clk);
    drive(S_WR);
    #1;
    chk("we_no_dena", 32'(mem_we), 32'h0);
    drive(S_WR | S_DENA | S_RD);
    #1;
    chk("we_dena", 32'(mem_we), 32'h1);
    chk("re", 32'(mem_re), 32'h1);
    chk("sto_addr", 32'(mem_addr), 32'h456);
    chk("sto_wdata", 32'(mem_wdata), 32'h7FFE);
    drive(8'h00);

    // Stack fill
    for (int i = 1; i <= 8; i++) begin
      cyc(S_LIR, 16'h9000);
      cyc(S_LACC, 16'(i));
      cyc(S_LIR, 16'hF000);
      cyc(S_LACC, 16'h0000);
    end
    chk("push8_err", 32'(stk_err), 32'h0);
    chk("push_acc_kept", 32'(mem_wdata), 32'h0008);
    cyc(S_LACC, 16'h0000);
    chk("push9_err", 32'(stk_err), 32'h1);

    // Stack drain
    cyc(S_LIR, 16'hE000);
    for (int i = 8; i >= 1; i--) begin
      cyc(S_LACC, 16'h0000);
      chk($sformatf("pop_%0d", i), 32'(mem_wdata), 32'(i));
    end
    cyc(S_LACC, 16'h0000);
    chk("pop_empty_acc", 32'(mem_wdata), 32'h0001);

    // Halt
    cyc(S_INC, 16'h0000);
    cyc(S_INC, 16'h0000);
    peek_pc("pre_halt_pc", 12'h002);
    cyc(S_LIR, 16'h9000);
    cyc(S_HALT | S_LACC, 16'h5555);
    chk("halted", 32'(halted), 32'h1);
    chk("halt_same_cycle_acc", 32'(mem_wdata), 32'h0001);
    cyc(S_INC, 16'h0000);
    peek_pc("halt_pc", 12'h002);
    cyc(S_LACC, 16'h1234);
    chk("halt_acc", 32'(mem_wdata), 32'h0001);
    @(negedge clk);
    drive(S_WR | S_DENA | S_RD);
    #1;
    chk("halt_we", 32'(mem_we), 32'h0);
    chk("halt_re", 32'(mem_re), 32'h0);
    drive(8'h00);

    // Reset mid-cycle clears everything immediately
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_halted", 32'(halted), 32'h0);
    chk("rst2_acc", 32'(mem_wdata), 32'h0);
    chk("rst2_stk_err", 32'(stk_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    peek_pc("rst2_pc", 12'h000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exec_datapath.md
# exec_datapath

Execution datapath that receives and carries out the strobes issued by the CPU control state machine (`inc_pc`, `load_pc`, `load_ir`, `load_acc`, `rd`, `wr`, `datactl_ena`, `halt`). It returns `opcode` and `zero` to that controller. It holds the program counter, instruction register, accumulator, ALU and a small hardware stack, and it drives the unified program/data memory port. The controller updates its strobes on the falling edge of `clk`; this block samples them on the rising edge.

## Interface
Parameters:
- `DATA_W`, 16: accumulator, ALU and memory data width. It must be at least `ADDR_W+4`.
- `ADDR_W`, 12: program counter and memory address width.
- `STACK_DEPTH`, 8: number of hardware stack entries. Must be a power of two.

Ports:
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inc_pc`, `load_pc`, `load_ir`, `load_acc`, `rd`, `wr`, `datactl_ena`, `halt`  in  1 each  controller strobes.
- `opcode`  out  4  `ir[DATA_W-1:DATA_W-4]`, returned to the controller.
- `zero`  out  1  high when `acc == 0` (combinational from the register).
- `mem_addr`  out  ADDR_W  memory address.
- `mem_rdata`  in  DATA_W  read data. Asynchronous memory, valid in the same cycle as the address.
- `mem_wdata`  out  DATA_W  always equal to `acc`.
- `mem_re`, `mem_we`  out  1  read enable and write enable.
- `halted`  out  1  sticky halt flag.
- `stk_err`  out  1  sticky stack overflow/underflow flag.

## Operation
- Instruction format: `opcode = ir[DATA_W-1:DATA_W-4]`, operand address `ir_addr = ir[ADDR_W-1:0]`.
- Address mux: `mem_addr = load_ir ? pc : ir_addr`.
- Memory enables:
  - `mem_re = rd & ~halted`.
  - `mem_we = wr & datactl_ena & ~halted`.
- Instruction fetch: `load_ir` → `ir <= mem_rdata`.
- PC update, priority `load_pc` > `inc_pc`:
  - `load_pc` → `pc <= ir_addr`.
  - `inc_pc` alone → `pc <= pc+1`, wrapping from all-ones to 0.
  - A fetch (`load_ir` with `inc_pc` in the same cycle) reads from the old `pc`.
- `load_acc` executes the current `opcode`, with `d = mem_rdata`:
  - ADD: `acc+d`. SUB: `acc-d`. Both modulo 2^DATA_W; carry and borrow are discarded.
  - MUL: low DATA_W bits of `acc*d`.
  - OR, AND, XOR: bitwise with `d`.
  - NOT: `~acc`.
  - LDA: `d`.
  - RL, RR: rotate `acc` by 1 bit.
  - PUSH: `stack[sp] <= acc`, `sp <= sp+1`, `acc` unchanged.
  - POP: `sp <= sp-1`, `acc <= stack[sp-1]`.
  - HLT, SKZ, STO, JMP: `acc` unchanged.
- Stack boundaries:
  - PUSH when full (`count == STACK_DEPTH`): no write, `sp` held, `stk_err <= 1`.
  - POP when empty: `acc` held, `sp` held, `stk_err <= 1`.
- Halt: `halt` → `halted <= 1`. `halted` stays set until `rst_n` is asserted. While `halted`:
  - `load_pc`, `inc_pc`, `load_ir` and `load_acc` are ignored.
  - `mem_re` and `mem_we` are forced to 0.
- Simultaneous `halt` and any load strobe: the load strobe is ignored in that same cycle.

## Timing
- Reset values (asynchronous on `rst_n` low):
  - `pc = 0`, `ir = 0` (so `opcode = HLT`), `acc = 0` (so `zero = 1`).
  - `sp = 0`, `halted = 0`, `stk_err = 0`.
  - Stack contents are not reset.
- Reset asserted mid-instruction: all registers clear immediately; a partial instruction has no residual effect.
- Each register updates on the first rising edge after its strobe is seen high. `zero` and `opcode` are valid in the following cycle.
- `mem_addr`, `mem_re` and `mem_we` are combinational from the strobes and registers: 0 cycles latency, stable half a cycle before the sampling edge.
- No handshake: every strobe is a one-cycle pulse and is acted on exactly once per cycle it is high.

## Structure
- Shared package `cpu_pkg`, used by both this block and the control state machine:
  - 4-bit opcode constants HLT=0 through PUSH=15.
  - Opcode typedef.
  - Default widths.
- One sub-module, `acc_stack`:
  - LIFO of `STACK_DEPTH` entries by DATA_W bits.
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, with asynchronous reset of the pointer.
- ALU as a combinational function inside `exec_datapath`.

## Test plan
- Reset, then fetch: `mem_rdata=16'hA005` with `load_ir`+`inc_pc` → `ir=16'hA005`, `opcode=4'hA`, `pc=1`. Then `load_acc` with `mem_rdata=16'h0000` → `acc=0`, `zero=1`.
- Arithmetic:
  - `acc=16'hFFFF`, ADD with `d=1` → `acc=0`, `zero=1`.
  - SUB with `d=1` → `acc=16'hFFFF`.
  - MUL `16'h0100 * 16'h0100` → `acc=0`.
  - RL of `16'h8001` → `16'h0003`.
- JMP sequence: `ir_addr=12'h123`, `load_pc` then `load_pc`+`inc_pc` → `pc=12'h123`. `inc_pc` alone at `pc=12'hFFF` → `pc=0`.
- STO: `wr` without `datactl_ena` → `mem_we=0`. `wr`+`datactl_ena` → `mem_we=1`, `mem_addr=ir_addr`, `mem_wdata=acc`.
- Stack:
  - 8 PUSHes of values 1..8, then 9th PUSH → `stk_err=1`.
  - 8 POPs return 8..1.
  - A further POP leaves `acc=1`.
- Halt: `halt` pulse → `halted=1`. Following `inc_pc`, `load_acc` and `wr` produce no change and `mem_we=0`. Asserting `rst_n` low clears `halted` and `pc`.
